// File: rtl/dps_decoder_20_pkg.sv
// Shared definitions for the 20-wire DPS (Fibonacci-numeral) decoder.
//   - FNS02..FNS21 : Fibonacci numeral weights (FNS02 = FNS03/2 = 1, 1, 2, 3, 5, ...)
//   - DBLEN20      : decoded data word width
//   - dps_weight() : weight of codeword bit k on the 20-wire bus
//   - dps_state_e  : decoder FSM states
package dps_decoder_20_pkg;

  localparam int unsigned CODE_W = 20;

  localparam int unsigned FNS02 = 1;
  localparam int unsigned FNS03 = 2;
  localparam int unsigned FNS04 = 3;
  localparam int unsigned FNS05 = 5;
  localparam int unsigned FNS06 = 8;
  localparam int unsigned FNS07 = 13;
  localparam int unsigned FNS08 = 21;
  localparam int unsigned FNS09 = 34;
  localparam int unsigned FNS10 = 55;
  localparam int unsigned FNS11 = 89;
  localparam int unsigned FNS12 = 144;
  localparam int unsigned FNS13 = 233;
  localparam int unsigned FNS14 = 377;
  localparam int unsigned FNS15 = 610;
  localparam int unsigned FNS16 = 987;
  localparam int unsigned FNS17 = 1597;
  localparam int unsigned FNS18 = 2584;
  localparam int unsigned FNS19 = 4181;
  localparam int unsigned FNS20 = 6765;
  localparam int unsigned FNS21 = 10946;

  // Data word is the narrowest width that still carries FNS21.
  localparam int unsigned DBLEN20 = $clog2(FNS21);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } dps_state_e;

  // Weight of codeword bit k. Bit 18 carries double weight and bit 19 sits
  // above it numerically lower; this is the DPS bus layout, not a typo.
  function automatic logic [DBLEN20-1:0] dps_weight(input logic [4:0] k);
    logic [DBLEN20-1:0] w;
    case (k)
      5'd0:    w = DBLEN20'(1);
      5'd1:    w = DBLEN20'(FNS02);
      5'd2:    w = DBLEN20'(FNS03);
      5'd3:    w = DBLEN20'(FNS04);
      5'd4:    w = DBLEN20'(FNS05);
      5'd5:    w = DBLEN20'(FNS06);
      5'd6:    w = DBLEN20'(FNS07);
      5'd7:    w = DBLEN20'(FNS08);
      5'd8:    w = DBLEN20'(FNS09);
      5'd9:    w = DBLEN20'(FNS10);
      5'd10:   w = DBLEN20'(FNS11);
      5'd11:   w = DBLEN20'(FNS12);
      5'd12:   w = DBLEN20'(FNS13);
      5'd13:   w = DBLEN20'(FNS14);
      5'd14:   w = DBLEN20'(FNS15);
      5'd15:   w = DBLEN20'(FNS16);
      5'd16:   w = DBLEN20'(FNS17);
      5'd17:   w = DBLEN20'(FNS18);
      5'd18:   w = DBLEN20'(2 * FNS19);
      5'd19:   w = DBLEN20'(FNS20);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dps_decoder_20_weight_lane.sv
// dps_weight_lane: combinational partial weighted sum of LANES codeword bits.
//   bits_i  [LANES]   codeword bits base_i .. base_i+LANES-1
//   base_i  [5]       codeword index of bits_i[0]
//   psum_o  [DBLEN20] sum of bits_i[j] * w(base_i + j), truncated to DBLEN20
module dps_weight_lane
  import dps_decoder_20_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic [LANES-1:0]   bits_i,
  input  logic [4:0]         base_i,
  output logic [DBLEN20-1:0] psum_o
);

  always_comb begin
    psum_o = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (bits_i[j]) begin
        psum_o = psum_o + dps_weight(base_i + 5'(j));
      end
    end
  end

endmodule

// File: rtl/dps_decoder_20.sv
// dps_decoder_20: receive-side decoder for the 20-wire DPS bus.
// Rebuilds the DBLEN20-bit data word as the weighted sum of the codeword
// bits, LANES bits per cycle, with valid/ready on both sides.
//   clock      rising-edge clock
//   rst_n      asynchronous active-low reset
//   code_in    [20] received codeword      in_valid / in_ready  : input handshake
//   data_out   [DBLEN20] decoded word      out_valid / out_ready: output handshake
module dps_decoder_20
  import dps_decoder_20_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DBLEN20-1:0] data_out,
  output logic               out_valid,
  input  logic               out_ready
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 5 ||
        LANES == 10 || LANES == 20)) begin : g_bad_lanes
    $error("dps_decoder_20: LANES must be one of 1, 2, 4, 5, 10, 20");
  end

  localparam int unsigned ITER      = CODE_W / LANES;
  localparam logic [4:0]  LANE_STEP = 5'(LANES);
  localparam logic [4:0]  LAST_IDX  = 5'((ITER - 1) * LANES);

  dps_state_e         state_q,  state_d;
  logic [CODE_W-1:0]  shadow_q, shadow_d;
  logic [DBLEN20-1:0] acc_q,    acc_d;
  logic [4:0]         idx_q,    idx_d;
  logic [DBLEN20-1:0] data_q,   data_d;

  logic [LANES-1:0]   lane_bits;
  logic [DBLEN20-1:0] lane_psum;
  logic [DBLEN20-1:0] acc_sum;

  assign lane_bits = LANES'(shadow_q >> idx_q);
  assign acc_sum   = acc_q + lane_psum;

  dps_weight_lane #(
    .LANES (LANES)
  ) u_lane (
    .bits_i (lane_bits),
    .base_i (idx_q),
    .psum_o (lane_psum)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shadow_d = code_in;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end

      ACCUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + LANE_STEP;
        // Final slice: the completed sum goes straight to the output register
        // on the same edge that enters DONE.
        if (idx_q == LAST_IDX) begin
          data_d  = acc_sum;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_dps_decoder_20.sv
// Directed self-checking bench for dps_decoder_20 (LANES = 4, 1, 20).
module tb_dps_decoder_20;
  import dps_decoder_20_pkg::*;

  localparam int unsigned DW    = DBLEN20;
  localparam int unsigned NI    = 3;     // 0: LANES=4, 1: LANES=1, 2: LANES=20
  localparam int unsigned NVALS = 2005;

  // Bench-side weight table, written out by hand from the bus definition.
  localparam int unsigned W [20] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144,
                                     233, 377, 610, 987, 1597, 2584, 8362, 6765};

  logic clock = 1'b0;
  logic rst_n;

  logic [19:0]   code_a      [NI];
  logic          in_valid_a  [NI];
  logic          out_ready_a [NI];
  logic          in_ready_a  [NI];
  logic          out_valid_a [NI];
  logic [DW-1:0] data_a      [NI];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned vals [NVALS];

  initial forever #5 clock = ~clock;

  dps_decoder_20 #(.LANES(4)) u_dut_l4 (
    .clock(clock), .rst_n(rst_n), .code_in(code_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .data_out(data_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]));

  dps_decoder_20 #(.LANES(1)) u_dut_l1 (
    .clock(clock), .rst_n(rst_n), .code_in(code_a[1]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .data_out(data_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]));

  dps_decoder_20 #(.LANES(20)) u_dut_l20 (
    .clock(clock), .rst_n(rst_n), .code_in(code_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .data_out(data_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Encoder model: pick the two top bits so the remainder fits bits 0..17,
  // then greedy Fibonacci decomposition.
  function automatic logic [19:0] encode(input int unsigned v);
    logic [19:0] c;
    int unsigned r;
    c = '0;
    if (v >= W[18] + W[19]) begin
      c[18] = 1'b1; c[19] = 1'b1; r = v - W[18] - W[19];
    end else if (v >= W[18]) begin
      c[18] = 1'b1; r = v - W[18];
    end else if (v >= W[19]) begin
      c[19] = 1'b1; r = v - W[19];
    end else begin
      r = v;
    end
    for (int k = 17; k >= 0; k--) begin
      if (r >= W[k]) begin
        c[k] = 1'b1;
        r = r - W[k];
      end
    end
    return c;
  endfunction

  // One word through instance i with out_ready held high.
  task automatic xfer(input int unsigned i, input logic [19:0] code,
                      input int unsigned exp, input int unsigned lat, input string tag);
    int unsigned n;
    code_a[i]     = code;
    in_valid_a[i] = 1'b1;
    n = 0;
    while (!in_ready_a[i] && n < 100) begin tick(); n++; end
    check({tag, "_rdy"}, 32'(in_ready_a[i]), 32'd1);
    tick();
    in_valid_a[i] = 1'b0;
    n = 1;
    while (!out_valid_a[i] && n < 100) begin tick(); n++; end
    check({tag, "_lat"}, n, lat);
    check(tag, 32'(data_a[i]), exp);
    tick();
  endtask

  task automatic rt_run(input int unsigned i, input int unsigned lat);
    for (int unsigned k = 0; k < NVALS; k++) begin
      xfer(i, encode(vals[k]), vals[k], lat, $sformatf("rt%0d_%0d", i, k));
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned seen;

    rst_n = 1'b0;
    for (int unsigned i = 0; i < NI; i++) begin
      code_a[i] = '0; in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b1;
    end
    vals[0] = 0; vals[1] = 1; vals[2] = FNS21 - 1; vals[3] = FNS21; vals[4] = (1 << DW) - 1;
    for (int unsigned k = 5; k < NVALS; k++) vals[k] = $urandom_range((1 << DW) - 1, 0);

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready_a[0]),  32'd1);
    check("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("rst_data",      32'(data_a[0]),      32'd0);
    check("rst_l1_ready",  32'(in_ready_a[1]),  32'd1);
    check("rst_l20_valid", 32'(out_valid_a[2]), 32'd0);
    tick();

    // Unit weights and boundaries on LANES=4
    xfer(0, 20'h00001, 1,     6, "w_bit0");
    xfer(0, 20'h00002, 1,     6, "w_bit1");
    xfer(0, 20'h80000, 6765,  6, "w_bit19");
    xfer(0, 20'h40000, 8362,  6, "w_bit18");
    xfer(0, 20'h20000, 2584,  6, "w_bit17");
    xfer(0, 20'hC0000, 15127, 6, "w_top2");
    xfer(0, 20'hFFFFF, 5507,  6, "w_allones_trunc");
    xfer(0, 20'h00000, 0,     6, "w_zero");

    // Back-pressure
    out_ready_a[0] = 1'b0;
    code_a[0]      = encode(1234);
    in_valid_a[0]  = 1'b1;
    check("bp_rdy", 32'(in_ready_a[0]), 32'd1);
    tick();
    in_valid_a[0] = 1'b0;
    n = 1;
    while (!out_valid_a[0] && n < 100) begin tick(); n++; end
    check("bp_lat", n, 32'd6);
    code_a[0]     = encode(4321);
    in_valid_a[0] = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      check("bp_hold_data",  32'(data_a[0]),      32'd1234);
      check("bp_hold_ready", 32'(in_ready_a[0]),  32'd0);
      check("bp_hold_valid", 32'(out_valid_a[0]), 32'd1);
      tick();
    end
    out_ready_a[0] = 1'b1;
    tick();
    check("bp_post_valid", 32'(out_valid_a[0]), 32'd0);
    check("bp_post_ready", 32'(in_ready_a[0]),  32'd1);
    tick();
    in_valid_a[0] = 1'b0;
    n = 1;
    while (!out_valid_a[0] && n < 100) begin tick(); n++; end
    check("bp_second_lat",  n, 32'd6);
    check("bp_second_data", 32'(data_a[0]), 32'd4321);
    tick();

    // Reset in the middle of ACCUM
    code_a[0]     = encode(3000);
    in_valid_a[0] = 1'b1;
    check("mr_rdy", 32'(in_ready_a[0]), 32'd1);
    tick();
    in_valid_a[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_in_ready",  32'(in_ready_a[0]),  32'd1);
    check("mr_out_valid", 32'(out_valid_a[0]), 32'd0);
    check("mr_data",      32'(data_a[0]),      32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int unsigned c = 0; c < 10; c++) begin
      if (out_valid_a[0]) seen++;
      tick();
    end
    check("mr_no_output", seen, 32'd0);
    xfer(0, encode(777), 777, 6, "mr_after");

    // Shadow register: code_in scrambled while accumulating
    code_a[0]     = encode(9999);
    in_valid_a[0] = 1'b1;
    check("sh_rdy", 32'(in_ready_a[0]), 32'd1);
    tick();
    in_valid_a[0] = 1'b0;
    n = 1;
    while (!out_valid_a[0] && n < 100) begin
      code_a[0] = 20'($urandom);
      tick();
      n++;
    end
    check("sh_lat",  n, 32'd6);
    check("sh_data", 32'(data_a[0]), 32'd9999);
    tick();

    // Round trip on all three lane widths in parallel
    fork
      rt_run(0, 6);
      rt_run(1, 21);
      rt_run(2, 2);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
